// File: rtl/motion_centroid_tracker.sv
// motion_centroid_tracker: per-frame motion-pixel centroid via restoring divide, with hold timer and box overlay.
// Latency: centroid and motion_valid update SUM_W+1 cycles after frame_done; box_active is combinational.
// No backpressure: a frame_done arriving while the divider runs is dropped and flagged on overrun.
// Optional feature macro: CENTER_SMOOTH_EN (halves each centroid step while already tracking).
module motion_centroid_tracker #(
  parameter int FRAME_W     = 320,
  parameter int FRAME_H     = 240,
  parameter int COORD_W     = 10,
  parameter int BOX_W       = 80,
  parameter int BOX_H       = 80,
  parameter int HOLD_CYCLES = 12_500_000,
  localparam int CNT_W      = $clog2(FRAME_W * FRAME_H + 1),
  localparam int SUM_W      = COORD_W + CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixel_valid,
  input  logic               diff_detected,
  input  logic [COORD_W-1:0] x_pixel,
  input  logic [COORD_W-1:0] y_pixel,
  input  logic               frame_done,
  input  logic [CNT_W-1:0]   detection_threshold,
  input  logic               display_enable,
  output logic [COORD_W-1:0] center_x,
  output logic [COORD_W-1:0] center_y,
  output logic               motion_valid,
  output logic               busy,
  output logic               overrun,
  output logic               box_active
);

  localparam int STEP_W = $clog2(SUM_W + 1);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [COORD_W-1:0] FW_LIM  = COORD_W'(FRAME_W);
  localparam logic [COORD_W-1:0] FH_LIM  = COORD_W'(FRAME_H);
  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(FRAME_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(FRAME_H - 1);
  localparam logic [COORD_W-1:0] HALF_BW = COORD_W'(BOX_W / 2);
  localparam logic [COORD_W-1:0] HALF_BH = COORD_W'(BOX_H / 2);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, TRACKING} state_t;

  logic [SUM_W-1:0]  sum_x, sum_y, q_x, q_y;
  logic [CNT_W-1:0]  pix_cnt, divisor, r_x, r_y, rx_nx, ry_nx;
  logic [CNT_W:0]    rx_sh, ry_sh;
  logic              x_ge, y_ge;
  logic [STEP_W-1:0] step;
  logic              pix_hit, div_start, div_done;
  logic [COORD_W-1:0] quo_x, quo_y, cx_nx, cy_nx;
  state_t            state, state_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;
  logic [COORD_W:0]  right_raw, bottom_raw;
  logic [COORD_W-1:0] box_left, box_right, box_top, box_bottom;
  logic              on_col, on_row;

  assign pix_hit   = pixel_valid && diff_detected && (x_pixel < FW_LIM) && (y_pixel < FH_LIM);
  assign div_start = frame_done && !busy && (pix_cnt > detection_threshold) && (pix_cnt != '0);
  assign div_done  = busy && (step == '0);
  assign quo_x     = q_x[COORD_W-1:0];
  assign quo_y     = q_y[COORD_W-1:0];
  assign motion_valid = (state == TRACKING);

  // Per-frame accumulators; frame_done wins over a coincident pixel and clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_x   <= '0;
      sum_y   <= '0;
      pix_cnt <= '0;
    end else if (frame_done) begin
      sum_x   <= '0;
      sum_y   <= '0;
      pix_cnt <= '0;
    end else if (pix_hit) begin
      sum_x   <= sum_x + SUM_W'(x_pixel);
      sum_y   <= sum_y + SUM_W'(y_pixel);
      pix_cnt <= pix_cnt + CNT_W'(1);
    end
  end

  // One restoring-division step for x and y sharing the same divisor.
  always_comb begin
    rx_sh = {r_x, q_x[SUM_W-1]};
    ry_sh = {r_y, q_y[SUM_W-1]};
    x_ge  = (rx_sh >= {1'b0, divisor});
    y_ge  = (ry_sh >= {1'b0, divisor});
    rx_nx = x_ge ? (rx_sh[CNT_W-1:0] - divisor) : rx_sh[CNT_W-1:0];
    ry_nx = y_ge ? (ry_sh[CNT_W-1:0] - divisor) : ry_sh[CNT_W-1:0];
  end

  // Divider: load snapshot on frame_done, SUM_W shift steps, then one completion cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_x     <= '0;
      q_y     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      divisor <= '0;
      step    <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= frame_done && busy;
      if (div_start) begin
        q_x     <= sum_x;
        q_y     <= sum_y;
        r_x     <= '0;
        r_y     <= '0;
        divisor <= pix_cnt;
        step    <= STEP_W'(SUM_W);
        busy    <= 1'b1;
      end else if (busy) begin
        if (step != '0) begin
          q_x  <= {q_x[SUM_W-2:0], x_ge};
          q_y  <= {q_y[SUM_W-2:0], y_ge};
          r_x  <= rx_nx;
          r_y  <= ry_nx;
          step <= step - STEP_W'(1);
        end else begin
          busy <= 1'b0;
        end
      end
    end
  end

`ifdef CENTER_SMOOTH_EN
  logic signed [COORD_W:0] dx, dy, sx, sy;
  // While tracking, move halfway toward the new centroid; from IDLE jump straight to it.
  always_comb begin
    dx    = $signed({1'b0, quo_x}) - $signed({1'b0, center_x});
    dy    = $signed({1'b0, quo_y}) - $signed({1'b0, center_y});
    sx    = $signed({1'b0, center_x}) + (dx >>> 1);
    sy    = $signed({1'b0, center_y}) + (dy >>> 1);
    cx_nx = (state == TRACKING) ? sx[COORD_W-1:0] : quo_x;
    cy_nx = (state == TRACKING) ? sy[COORD_W-1:0] : quo_y;
  end
`else
  // Centroid is the truncated quotient.
  always_comb begin
    cx_nx = quo_x;
    cy_nx = quo_y;
  end
`endif

  // Center register: only changes on divide completion, otherwise holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      center_x <= '0;
      center_y <= '0;
    end else if (div_done) begin
      center_x <= cx_nx;
      center_y <= cy_nx;
    end
  end

  // Tracking state and hold counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
    end
  end

  // Tracking FSM: completion enters/refreshes TRACKING; hold expiry returns to IDLE.
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    case (state)
      IDLE: begin
        if (div_done) begin
          state_nx = TRACKING;
          hold_nx  = '0;
        end
      end
      TRACKING: begin
        if (div_done) begin
          hold_nx = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx = IDLE;
          hold_nx  = '0;
        end else begin
          hold_nx = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        hold_nx  = '0;
      end
    endcase
  end

  // Box edges clamped to the frame, and border hit test for the current pixel.
  always_comb begin
    right_raw  = {1'b0, center_x} + {1'b0, HALF_BW};
    bottom_raw = {1'b0, center_y} + {1'b0, HALF_BH};
    box_left   = (center_x >= HALF_BW) ? (center_x - HALF_BW) : '0;
    box_top    = (center_y >= HALF_BH) ? (center_y - HALF_BH) : '0;
    box_right  = (right_raw  > {1'b0, X_MAX}) ? X_MAX : right_raw[COORD_W-1:0];
    box_bottom = (bottom_raw > {1'b0, Y_MAX}) ? Y_MAX : bottom_raw[COORD_W-1:0];
    on_col     = ((x_pixel == box_left) || (x_pixel == box_right)) &&
                 (y_pixel >= box_top) && (y_pixel <= box_bottom);
    on_row     = ((y_pixel == box_top) || (y_pixel == box_bottom)) &&
                 (x_pixel >= box_left) && (x_pixel <= box_right);
    box_active = display_enable && motion_valid && (on_col || on_row);
  end

endmodule

// File: tb/tb_motion_centroid_tracker.sv
// Scoreboard bench for motion_centroid_tracker with HOLD_CYCLES=100.
// Stimulus pushes expected centroids and timing windows; a negedge monitor checks them.
module tb_motion_centroid_tracker;
  localparam int COORD_W = 10;
  localparam int FW = 320;
  localparam int FH = 240;
  localparam int HOLD = 100;
  localparam int CNT_W = $clog2(FW * FH + 1);
  localparam int SUM_W = COORD_W + CNT_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pixel_valid = 1'b0, diff_detected = 1'b0, frame_done = 1'b0, display_enable = 1'b0;
  logic [COORD_W-1:0] x_pixel = '0, y_pixel = '0;
  logic [CNT_W-1:0] detection_threshold = '0;
  logic [COORD_W-1:0] center_x, center_y;
  logic motion_valid, busy, overrun, box_active;

  motion_centroid_tracker #(.FRAME_W(FW), .FRAME_H(FH), .COORD_W(COORD_W), .BOX_W(80),
                            .BOX_H(80), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(rst), .pixel_valid(pixel_valid), .diff_detected(diff_detected),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .frame_done(frame_done),
    .detection_threshold(detection_threshold), .display_enable(display_enable),
    .center_x(center_x), .center_y(center_y), .motion_valid(motion_valid), .busy(busy),
    .overrun(overrun), .box_active(box_active));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cx; int cy; int dc; } exp_t;
  exp_t exp_q[$];
  bit done_at[int];
  bit ov_at[int];
  int m_sx = 0, m_sy = 0, m_cnt = 0, thr = 0;
  int div_start = 0, div_end = 0, track_end = 0;
  int total = 0, bad = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Reference: centroid = integer mean of qualifying pixels, divide occupies SUM_W+1 cycles.
  task automatic model_frame_done();
    int c;
    c = cyc + 1;
    if (c > div_start && c <= div_end) begin
      ov_at[c] = 1'b1;
    end else if (m_cnt > thr && m_cnt != 0) begin
      exp_t e;
      div_start = c;
      div_end = c + SUM_W + 1;
      e.cx = (m_sx / m_cnt) % 1024;
      e.cy = (m_sy / m_cnt) % 1024;
      e.dc = div_end;
      exp_q.push_back(e);
      done_at[div_end] = 1'b1;
    end
    m_sx = 0; m_sy = 0; m_cnt = 0;
  endtask

  task automatic drive(input bit v, input bit d, input int x, input int y, input bit fd);
    @(posedge clk); #1;
    pixel_valid = v; diff_detected = d; x_pixel = COORD_W'(x); y_pixel = COORD_W'(y);
    frame_done = fd;
    detection_threshold = CNT_W'(thr);
    if (fd) model_frame_done();
    else if (v && d && x < FW && y < FH) begin
      m_sx += x; m_sy += y; m_cnt++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic model_clear();
    exp_q.delete(); done_at.delete(); ov_at.delete();
    div_start = 0; div_end = 0; track_end = 0;
    m_sx = 0; m_sy = 0; m_cnt = 0;
  endtask

  function automatic int box_exp(input int x, input int y, input int cx, input int cy);
    int l, r, t, b;
    l = (cx - 40 < 0) ? 0 : cx - 40;
    r = (cx + 40 > FW - 1) ? FW - 1 : cx + 40;
    t = (cy - 40 < 0) ? 0 : cy - 40;
    b = (cy + 40 > FH - 1) ? FH - 1 : cy + 40;
    return (((x == l || x == r) && y >= t && y <= b) ||
            ((y == t || y == b) && x >= l && x <= r)) ? 1 : 0;
  endfunction

  // Monitor: per-cycle busy/motion_valid/overrun windows, and centroid on each busy fall.
  initial begin
    bit prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
      end else begin
        if (done_at.exists(cyc)) track_end = cyc + HOLD;
        chk("busy", int'(busy), (cyc >= div_start && cyc < div_end) ? 1 : 0);
        chk("motion_valid", int'(motion_valid), (cyc < track_end) ? 1 : 0);
        chk("overrun", int'(overrun), ov_at.exists(cyc) ? 1 : 0);
        if (prev_busy && !busy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("done_cycle", cyc, e.dc);
            chk("center_x", int'(center_x), e.cx);
            chk("center_y", int'(center_y), e.cy);
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int k, e1, e2, k2;
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    display_enable = 1'b1;
    @(negedge clk);
    chk("rst_center_x", int'(center_x), 0);
    chk("rst_center_y", int'(center_y), 0);
    chk("rst_motion_valid", int'(motion_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_box_active", int'(box_active), 0);
    display_enable = 1'b0;

    // Count equal to threshold: no divide
    thr = 3;
    drive(1, 1, 10, 10, 0); drive(1, 1, 20, 20, 0); drive(1, 1, 30, 30, 0);
    drive(0, 0, 0, 0, 1);
    idle(SUM_W + 5);
    chk("below_thr_mv", int'(motion_valid), 0);
    chk("below_thr_busy", int'(busy), 0);

    // Four-pixel square centroid
    drive(1, 1, 100, 50, 0); drive(1, 1, 102, 50, 0);
    drive(1, 1, 100, 54, 0); drive(1, 1, 102, 54, 0);
    drive(0, 0, 0, 0, 1);
    idle(SUM_W + 3);
    chk("sq_center_x", int'(center_x), 101);
    chk("sq_center_y", int'(center_y), 52);
    chk("sq_mv", int'(motion_valid), 1);
    idle(HOLD + 5);

    // Hold timing with a refresh 50 cycles into tracking
    thr = 0;
    drive(1, 1, 200, 100, 0);
    drive(0, 0, 0, 0, 1);
    e1 = cyc + 1 + SUM_W + 1;
    k2 = e1 + 50 - (SUM_W + 2);
    while (cyc < k2 - 2) drive(0, 0, 0, 0, 0);
    drive(1, 1, 210, 110, 0);
    drive(0, 0, 0, 0, 1);
    e2 = cyc + 1 + SUM_W + 1;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!motion_valid) break;
    end
    chk("hold_fall_cycle", cyc, e2 + HOLD);
    chk("hold_refresh_gap", e2 - e1, 50);

    // Overrun: second frame_done while dividing
    drive(1, 1, 30, 40, 0); drive(1, 1, 50, 60, 0);
    drive(0, 0, 0, 0, 1);
    idle(10);
    drive(1, 1, 300, 200, 0);
    drive(0, 0, 0, 0, 1);
    idle(SUM_W + 5);
    chk("ovr_center_x", int'(center_x), 40);
    chk("ovr_center_y", int'(center_y), 50);

    // Box clamping around (10,230)
    drive(1, 1, 10, 230, 0);
    drive(0, 0, 0, 0, 1);
    idle(SUM_W + 3);
    display_enable = 1'b1;
    @(negedge clk); x_pixel = 0; y_pixel = 200; #1;
    chk("box_0_200", int'(box_active), 1);
    @(negedge clk); x_pixel = 1; y_pixel = 200; #1;
    chk("box_1_200", int'(box_active), 0);
    @(negedge clk); x_pixel = 50; y_pixel = 239; #1;
    chk("box_50_239", int'(box_active), 1);
    @(negedge clk); x_pixel = 51; y_pixel = 190; #1;
    chk("box_51_190", int'(box_active), 0);
    for (int i = 0; i < 12; i++) begin
      int rx, ry;
      rx = $urandom_range(0, 60);
      ry = $urandom_range(185, 245);
      @(negedge clk); x_pixel = COORD_W'(rx); y_pixel = COORD_W'(ry); #1;
      chk("box_rand", int'(box_active), box_exp(rx, ry, 10, 230));
    end
    @(negedge clk); display_enable = 1'b0; x_pixel = 0; y_pixel = 200; #1;
    chk("box_disp_off", int'(box_active), 0);

    // Reset in the middle of a divide
    drive(1, 1, 80, 90, 0);
    drive(0, 0, 0, 0, 1);
    idle(10);
    display_enable = 1'b1;
    @(posedge clk); #3;
    rst = 1'b1;
    model_clear();
    #1;
    chk("mid_rst_center_x", int'(center_x), 0);
    chk("mid_rst_center_y", int'(center_y), 0);
    chk("mid_rst_mv", int'(motion_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    chk("mid_rst_box", int'(box_active), 0);
    display_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 1, 150, 120, 0); drive(1, 1, 152, 122, 0);
    drive(0, 0, 0, 0, 1);
    idle(SUM_W + 3);
    chk("post_rst_center_x", int'(center_x), 151);
    chk("post_rst_center_y", int'(center_y), 121);

    // Randomized frames, with gaps short enough to provoke overruns
    for (int f = 0; f < 30; f++) begin
      int np;
      thr = $urandom_range(0, 6);
      np = $urandom_range(0, 14);
      for (int p = 0; p < np; p++)
        drive(($urandom % 4) != 0, ($urandom % 3) != 0,
              $urandom_range(0, 340), $urandom_range(0, 260), 0);
      if ($urandom % 4 == 0)
        drive(1, 1, $urandom_range(0, 319), $urandom_range(0, 239), 1);
      else
        drive(0, 0, 0, 0, 1);
      idle($urandom_range(1, 40));
    end
    idle(SUM_W + 5);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/motion_centroid_tracker.md
MOTION_CENTROID_TRACKER -- requirements
Module: motion_centroid_tracker

Interface
REQ-001 SHALL have parameter FRAME_W, default 320: active frame width in pixels.
REQ-002 SHALL have parameter FRAME_H, default 240: active frame height in pixels.
REQ-003 SHALL have parameter COORD_W, default 10: coordinate width in bits; requires 2^COORD_W > FRAME_W and 2^COORD_W > FRAME_H.
REQ-004 SHALL have parameter BOX_W, default 80: bounding-box width in pixels.
REQ-005 SHALL have parameter BOX_H, default 80: bounding-box height in pixels.
REQ-006 SHALL have parameter HOLD_CYCLES, default 12_500_000: number of clk cycles the box stays valid after the last detection.
REQ-007 SHALL have local CNT_W = clog2(FRAME_W*FRAME_H+1) and local SUM_W = COORD_W+CNT_W.
REQ-008 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-009 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-010 SHALL have port pixel_valid, input, 1 bit: qualifies diff_detected, x_pixel and y_pixel.
REQ-011 SHALL have port diff_detected, input, 1 bit: current pixel is a motion pixel.
REQ-012 SHALL have ports x_pixel and y_pixel, input, COORD_W bits each: current pixel coordinate (accumulation and display).
REQ-013 SHALL have port frame_done, input, 1 bit: one-cycle end-of-frame pulse.
REQ-014 SHALL have port detection_threshold, input, CNT_W bits: minimum motion-pixel count.
REQ-015 SHALL have port display_enable, input, 1 bit: active video.
REQ-016 SHALL have ports center_x and center_y, output, COORD_W bits each: registered centroid.
REQ-017 SHALL have port motion_valid, output, 1 bit: in TRACKING state.
REQ-018 SHALL have port busy, output, 1 bit: divider running.
REQ-019 SHALL have port overrun, output, 1 bit: one-cycle pulse when a frame is dropped.
REQ-020 SHALL have port box_active, output, 1 bit: current pixel lies on the box border.

Function
REQ-021 SHALL add x/y to SUM_W sum_x/sum_y and increment the CNT_W count when pixel_valid && diff_detected && x<FRAME_W && y<FRAME_H and frame_done=0.
REQ-022 SHALL, on frame_done, snapshot sums and count, then clear the accumulators in the same cycle; a pixel coinciding with frame_done is discarded.
REQ-023 SHALL, if the snapshot count > detection_threshold and count != 0 and the divider is idle, start the divider; otherwise discard the snapshot with no divide.
REQ-024 SHALL compute the divider as sequential restoring division, x and y in parallel, one quotient bit per cycle; the result is available exactly SUM_W+1 cycles after frame_done, and busy is high throughout.
REQ-025 SHALL, when frame_done arrives while busy, drop the new snapshot, keep the current divide running and pulse overrun for 1 cycle; the accumulators still clear.
REQ-026 SHALL, on divide completion, truncate the quotients to COORD_W bits, update center_x/center_y in the next cycle, enter TRACKING and clear the hold counter.
REQ-027 SHALL implement tracking FSM IDLE->TRACKING on divide completion; TRACKING->IDLE when the hold counter reaches HOLD_CYCLES-1 with no completion that cycle; completion in TRACKING restarts the hold counter.
REQ-028 SHALL drive motion_valid = (state==TRACKING); center outputs hold their last value in IDLE.
REQ-029 SHALL compute box_left = center_x-BOX_W/2, clamped to 0, and box_right = center_x+BOX_W/2, clamped to FRAME_W-1; box_top and box_bottom are computed likewise using BOX_H and FRAME_H.
REQ-030 SHALL drive box_active combinationally = display_enable && motion_valid && pixel on a box edge row or column within the box span.

Reset
REQ-031 SHALL, on reset assertion, immediately clear sums, count, snapshot, divider, hold counter, center_x/center_y (to 0), motion_valid, busy, overrun and box_active, and set state to IDLE, including mid-divide; no result is produced for an aborted divide.

Configuration
REQ-032 SHALL, with macro CENTER_SMOOTH_EN defined, update the center in TRACKING to old+((new-old)>>>1), using signed arithmetic with COORD_W+1 bits; the first update from IDLE loads new directly.
REQ-033 SHALL, with CENTER_SMOOTH_EN not defined, load the center directly from the quotient.

Verification
REQ-034 SHALL cover: 4 motion pixels at (100,50),(102,50),(100,54),(102,54), threshold 3, then frame_done -> busy for SUM_W+1 cycles, center=(101,52), motion_valid=1.
REQ-035 SHALL cover: 3 motion pixels with threshold 3 -> no divide, busy=0, motion_valid stays 0.
REQ-036 SHALL cover: HOLD_CYCLES=100 with a single detection -> motion_valid falls exactly 100 cycles after entering TRACKING; a second detection at cycle 50 extends it.
REQ-037 SHALL cover: frame_done twice within SUM_W cycles -> overrun pulses once and the center reflects the first frame only.
REQ-038 SHALL cover: center (10,230) -> box spans x 0..50 and y 190..239; box_active asserts at (0,200) and deasserts at (1,200).
REQ-039 SHALL cover: reset asserted mid-divide -> all outputs 0 within the same cycle, and the next frame divides normally.
